// File: rtl/ad_main_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | ad_main_pkg                                                      |
// | FSM states and default timing for the AD7606 sequencer.          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package ad_main_pkg;

  typedef enum logic [2:0] {
    RST_AD    = 3'd0,
    IDLE      = 3'd1,
    CONV      = 3'd2,
    WAIT_BUSY = 3'd3,
    READ      = 3'd4,
    TX        = 3'd5
  } ad_state_e;

  localparam int DEF_CLK_FREQ     = 50_000_000;
  localparam int DEF_BAUD         = 115200;
  localparam int DEF_SAMPLE_CYC   = 50_000;
  localparam int DEF_RST_CYC      = 10;
  localparam int DEF_CONV_LOW_CYC = 5;
  localparam int DEF_BUSY_DLY_CYC = 5;
  localparam int DEF_RD_LOW_CYC   = 3;
  localparam int DEF_RD_HIGH_CYC  = 2;

  // Width of the shared per-state cycle counter.
  localparam int CNT_W = 16;

  function automatic int bit_cycles(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ad_main_function_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | uart_tx                                                          |
// | 8N1 transmitter; busy from the cycle after start to stop-bit end.|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module uart_tx #(
  parameter int BIT_CYC = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       start,
  output logic       tx,
  output logic       busy
);

  localparam int BW = $clog2(BIT_CYC + 1);
  localparam logic [BW-1:0] c_bit_last = BW'(BIT_CYC - 1);

  logic [BW-1:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    data_q, data_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;

  // bit_idx: 0 = start bit, 1..8 = data bits, 9 = stop bit
  always_comb begin
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    data_d     = data_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    if (!busy_q) begin
      if (start) begin
        busy_d     = 1'b1;
        tx_d       = 1'b0;
        data_d     = data;
        bit_idx_d  = 4'd0;
        baud_cnt_d = '0;
      end
    end else if (baud_cnt_q == c_bit_last) begin
      baud_cnt_d = '0;
      if (bit_idx_q == 4'd9) begin
        busy_d = 1'b0;
        tx_d   = 1'b1;
      end else begin
        bit_idx_d = bit_idx_q + 4'd1;
        tx_d      = (bit_idx_q == 4'd8) ? 1'b1 : data_q[bit_idx_q[2:0]];
      end
    end else begin
      baud_cnt_d = baud_cnt_q + BW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      data_q     <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      data_q     <= data_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule
`default_nettype wire

// File: rtl/ad_main_function.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | ad_main_function                                                 |
// | AD7606 conversion sequencer; reports channel 1 over UART 8N1.    |
// | Option macro: FRSTDATA_CHECK_EN (drop reads without FRSTDATA).   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ad_main_function
  import ad_main_pkg::*;
#(
  parameter int CLK_FREQ     = DEF_CLK_FREQ,
  parameter int BAUD         = DEF_BAUD,
  parameter int SAMPLE_CYC   = DEF_SAMPLE_CYC,
  parameter int RST_CYC      = DEF_RST_CYC,
  parameter int CONV_LOW_CYC = DEF_CONV_LOW_CYC,
  parameter int BUSY_DLY_CYC = DEF_BUSY_DLY_CYC,
  parameter int RD_LOW_CYC   = DEF_RD_LOW_CYC,
  parameter int RD_HIGH_CYC  = DEF_RD_HIGH_CYC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ad_data,
  input  logic        ad_busy,
  input  logic        first_data,
  output logic [2:0]  ad_os,
  output logic        ad_cs,
  output logic        ad_rd,
  output logic        ad_reset,
  output logic        ad_convstab,
  output logic        tx_reg
);

  localparam int BIT_CYC = bit_cycles(CLK_FREQ, BAUD);
  localparam int PER_W   = $clog2(SAMPLE_CYC + 1);

  localparam logic [CNT_W-1:0] c_rst_last  = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] c_conv_last = CNT_W'(CONV_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] c_busy_dly  = CNT_W'(BUSY_DLY_CYC);
  localparam logic [CNT_W-1:0] c_rd_low    = CNT_W'(RD_LOW_CYC);
  localparam logic [CNT_W-1:0] c_rd_cap    = CNT_W'(RD_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] c_rd_last   = CNT_W'(RD_LOW_CYC + RD_HIGH_CYC - 1);
  localparam logic [PER_W-1:0] c_per_last  = PER_W'(SAMPLE_CYC - 1);

  ad_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       ch_q, ch_d;
  logic [PER_W-1:0] period_q, period_d;
  logic [15:0]      ch1_q, ch1_d;
  logic [1:0]       tx_phase_q, tx_phase_d;
  logic             discard_q, discard_d;

  logic             uart_start;
  logic [7:0]       uart_data;
  logic             uart_busy;
  logic             uart_tx_line;

`ifndef FRSTDATA_CHECK_EN
  logic unused_first_data;
  assign unused_first_data = first_data;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ch_d       = ch_q;
    ch1_d      = ch1_q;
    tx_phase_d = tx_phase_q;
    discard_d  = discard_q;
    uart_start = 1'b0;
    // Period saturates at expiry so a late TX only defers the next CONV.
    period_d   = period_q;
    if ((state_q != RST_AD) && (period_q != c_per_last))
      period_d = period_q + PER_W'(1);

    unique case (state_q)
      RST_AD: begin
        if (cnt_q == c_rst_last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE: begin
        if (period_q == c_per_last) begin
          state_d  = CONV;
          cnt_d    = '0;
          period_d = '0;
        end
      end
      CONV: begin
        if (cnt_q == c_conv_last) begin
          state_d = WAIT_BUSY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_BUSY: begin
        if (cnt_q != c_busy_dly) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (!ad_busy) begin
          state_d   = READ;
          cnt_d     = '0;
          ch_d      = '0;
          discard_d = 1'b0;
        end
      end
      READ: begin
        if ((ch_q == 3'd0) && (cnt_q == c_rd_cap)) begin
`ifdef FRSTDATA_CHECK_EN
          if (first_data) ch1_d = ad_data;
          else            discard_d = 1'b1;
`else
          ch1_d = ad_data;
`endif
        end
        if (cnt_q == c_rd_last) begin
          cnt_d = '0;
          if (ch_q == 3'd7) begin
            state_d    = discard_q ? IDLE : TX;
            tx_phase_d = 2'd0;
          end else begin
            ch_d = ch_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TX: begin
        // phase 0: launch high byte; 1: launch low byte when free; 2: wait for stop end
        unique case (tx_phase_q)
          2'd0: begin
            uart_start = 1'b1;
            tx_phase_d = 2'd1;
          end
          2'd1: begin
            if (!uart_busy) begin
              uart_start = 1'b1;
              tx_phase_d = 2'd2;
            end
          end
          default: begin
            if (!uart_busy) state_d = IDLE;
          end
        endcase
      end
      default: state_d = RST_AD;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= RST_AD;
      cnt_q      <= '0;
      ch_q       <= '0;
      period_q   <= '0;
      ch1_q      <= '0;
      tx_phase_q <= '0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ch_q       <= ch_d;
      period_q   <= period_d;
      ch1_q      <= ch1_d;
      tx_phase_q <= tx_phase_d;
      discard_q  <= discard_d;
    end
  end

  assign uart_data = (tx_phase_q == 2'd0) ? ch1_q[15:8] : ch1_q[7:0];

  uart_tx #(
    .BIT_CYC (BIT_CYC)
  ) u_uart_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (uart_data),
    .start (uart_start),
    .tx    (uart_tx_line),
    .busy  (uart_busy)
  );

  assign ad_os       = 3'b000;
  assign ad_reset    = (state_q == RST_AD);
  assign ad_convstab = (state_q != CONV);
  assign ad_cs       = (state_q != READ);
  assign ad_rd       = !((state_q == READ) && (cnt_q < c_rd_low));
  assign tx_reg      = uart_tx_line;

endmodule
`default_nettype wire

// File: tb/tb_ad_main_function.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ad_main_function                                              |
// | Randomized directed bench for the AD7606 sequencer.              |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_ad_main_function;

  localparam int CLK_FREQ     = 1000;
  localparam int BAUD         = 100;
  localparam int BIT          = CLK_FREQ / BAUD;
  localparam int SAMPLE_CYC   = 600;
  localparam int RST_CYC      = 10;
  localparam int CONV_LOW_CYC = 5;
  localparam int BUSY_DLY_CYC = 5;
  localparam int RD_LOW_CYC   = 3;
  localparam int RD_HIGH_CYC  = 2;
  localparam int NITER        = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] ad_data = 16'h0000;
  logic        ad_busy = 1'b0;
  logic        first_data = 1'b1;
  logic [2:0]  ad_os;
  logic        ad_cs, ad_rd, ad_reset, ad_convstab, tx_reg;

  ad_main_function #(
    .CLK_FREQ     (CLK_FREQ),
    .BAUD         (BAUD),
    .SAMPLE_CYC   (SAMPLE_CYC),
    .RST_CYC      (RST_CYC),
    .CONV_LOW_CYC (CONV_LOW_CYC),
    .BUSY_DLY_CYC (BUSY_DLY_CYC),
    .RD_LOW_CYC   (RD_LOW_CYC),
    .RD_HIGH_CYC  (RD_HIGH_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ad_data     (ad_data),
    .ad_busy     (ad_busy),
    .first_data  (first_data),
    .ad_os       (ad_os),
    .ad_cs       (ad_cs),
    .ad_rd       (ad_rd),
    .ad_reset    (ad_reset),
    .ad_convstab (ad_convstab),
    .tx_reg      (tx_reg)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic       txq[$];
  int         txq_base;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         frame_bad;
  int         last_end;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Record the TX line each cycle until the next CONVST falling edge.
  task automatic wait_fall(output bit ok);
    int n;
    txq.delete();
    txq_base = cyc;
    n = 0;
    while (ad_convstab && n < SAMPLE_CYC + 1000) begin
      txq.push_back(tx_reg);
      step();
      n++;
    end
    ok = !ad_convstab;
  endtask

  // Decode 8N1 frames by sampling mid-bit in the recorded line.
  task automatic decode_tx();
    int i;
    logic [7:0] b;
    got_q.delete();
    frame_bad = 0;
    last_end  = -1;
    i = 0;
    while (i < txq.size()) begin
      if (txq[i] == 1'b0) begin
        if (i + BIT/2 + 9*BIT >= txq.size()) begin
          frame_bad++;
          break;
        end
        if (txq[i + BIT/2] !== 1'b0) frame_bad++;
        for (int k = 0; k < 8; k++) b[k] = txq[i + BIT/2 + (k+1)*BIT];
        if (txq[i + BIT/2 + 9*BIT] !== 1'b1) frame_bad++;
        got_q.push_back(b);
        last_end = txq_base + i + 10*BIT;
        i = i + BIT/2 + 9*BIT;
      end
      i++;
    end
  endtask

  initial begin
    bit          ok;
    bit          check_en;
    int          hi, n, w, fall, ideal, act_end, ceil_c, r_cyc, busy_low, cs_fall, bh;
    int          lo, hrun, pulses, low_bad, high_bad;
    logic [15:0] chv[8];
    logic [15:0] model_ch1;
    logic        fd0;

`ifdef FRSTDATA_CHECK_EN
    check_en = 1'b1;
`else
    check_en = 1'b0;
`endif
    model_ch1 = 16'h0000;

    #90;
    check("rst_ad_os", int'(ad_os), 0);
    check("rst_ad_cs", int'(ad_cs), 1);
    check("rst_ad_rd", int'(ad_rd), 1);
    check("rst_ad_reset", int'(ad_reset), 1);
    check("rst_ad_convstab", int'(ad_convstab), 1);
    check("rst_tx_reg", int'(tx_reg), 1);
    #10;
    rst_n = 1'b0;

    hi = 0;
    n  = 0;
    while (ad_reset && n < 100) begin
      hi++;
      step();
      n++;
    end
    check("ad_reset_len", hi, RST_CYC);
    ideal   = cyc + SAMPLE_CYC;
    act_end = cyc;

    for (int it = 0; it <= NITER; it++) begin
      wait_fall(ok);
      if (!ok) begin
        checks++;
        errors++;
        $error("FAIL conv_timeout observed=%0d expected=%0d", int'(ad_convstab), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "run aborted");
      end else begin
        decode_tx();
        check("frame_count", got_q.size(), exp_q.size());
        check("frame_format", frame_bad, 0);
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
          check($sformatf("frame_byte%0d", k), int'(got_q[k]), int'(exp_q[k]));
        if (got_q.size() > 0) act_end = last_end;
        exp_q.delete();

        fall   = cyc;
        ceil_c = (ideal > act_end + 3) ? ideal : act_end + 3;
        check("conv_start_time", int'(fall >= ideal && fall > act_end && fall <= ceil_c), 1);
        if (it == NITER) break;
        ideal = fall + SAMPLE_CYC;

        chv[0] = (it == 0) ? 16'hFFFF : (it == 1) ? 16'h0FFF : 16'($urandom);
        for (int k = 1; k < 8; k++) chv[k] = 16'($urandom);
        fd0 = (it == 2) ? 1'b0 : (it < 5) ? 1'b1 : ($urandom_range(0, 3) != 0);
        bh  = (it == 3) ? 400 : (it == 4) ? 20 : int'($urandom_range(0, 15));

        w = 0;
        while (!ad_convstab && w < 100) begin
          w++;
          step();
        end
        check("convst_low_width", w, CONV_LOW_CYC);

        r_cyc      = cyc;
        ad_busy    = (bh > 0);
        ad_data    = chv[0];
        first_data = fd0;
        busy_low   = (bh > 0) ? -1 : r_cyc;
        n = 0;
        while (n < 2000) begin
          step();
          n++;
          if (!ad_cs) break;
          if (bh > 0) begin
            bh--;
            if (bh == 0) begin
              ad_busy  = 1'b0;
              busy_low = cyc;
            end
          end
        end
        if (ad_cs) begin
          checks++;
          errors++;
          $error("FAIL read_timeout observed=%0d expected=%0d", int'(ad_cs), 0);
          $display("Result: errors=%0d of %0d checks", errors, checks);
          $fatal(1, "run aborted");
        end else begin
          cs_fall = cyc;
          ceil_c  = ((r_cyc + BUSY_DLY_CYC) > busy_low ? (r_cyc + BUSY_DLY_CYC) : busy_low) + 2;
          check("read_after_busy", int'(busy_low >= 0 && cs_fall > busy_low), 1);
          check("read_start_time", int'(cs_fall >= r_cyc + BUSY_DLY_CYC && cs_fall <= ceil_c), 1);
          check("ad_os_const", int'(ad_os), 0);

          lo = 0; hrun = 0; pulses = 0; low_bad = 0; high_bad = 0; n = 0;
          while (!ad_cs && n < 200) begin
            if (!ad_rd) begin
              if (hrun > 0) begin
                if (hrun != RD_HIGH_CYC) high_bad++;
                hrun = 0;
              end
              lo++;
            end else begin
              if (lo > 0) begin
                if (lo != RD_LOW_CYC) low_bad++;
                lo = 0;
                pulses++;
                first_data = 1'b0;
                if (pulses < 8) ad_data = chv[pulses];
              end
              hrun++;
            end
            step();
            n++;
          end
          if (lo > 0) low_bad++;
          if (hrun != RD_HIGH_CYC) high_bad++;
          check("rd_pulses", pulses, 8);
          check("rd_low_width", low_bad, 0);
          check("rd_high_width", high_bad, 0);
          check("cs_high_after_read", int'(ad_cs), 1);

          act_end = cyc;
          if (!(check_en && !fd0)) begin
            model_ch1 = chv[0];
            exp_q.push_back(model_ch1[15:8]);
            exp_q.push_back(model_ch1[7:0]);
          end
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
